regfile_mp: RTL and testbench

- Parametrised successor to the single-issue register file in the RISC-V core.
- Provides a configurable number of independent read ports, one write port, and hardwired-zero register 0.
- Reads are registered (1-cycle latency), with write-to-read bypass.
- A post-reset clear sequencer zeroes every entry and reports readiness to the decode stage, so the pipeline never reads stale data.

---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired x0, registered reads with
// write-first bypass, and a post-reset sequencer that zeroes all entries.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   res,
  output logic                   ready,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_valid
);

  localparam int NA = 2 ** AW;
  // One bit per encodable address: set only for 1..DEPTH-1
  localparam logic [NA-1:0] LEGAL =
    ({NA{1'b1}} >> (NA - DEPTH)) & ~NA'(1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          wr_ok;

  logic [XLEN-1:0] mem [DEPTH];

  assign wr_ok = (state == RUN) && wr_en && LEGAL[wr_addr];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= (state_nxt == RUN);
    end
  end

  // Storage has no reset; only the sequencer clears it
  always_ff @(posedge clk) begin
    if (!res) begin
      if (state == INIT)
        mem[cnt] <= '0;
      else if (wr_ok)
        mem[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;

    assign a = rd_addr[gi*AW +: AW];

    always_comb begin
      v = '0;
      if (LEGAL[a])
        v = (wr_en && wr_addr == a) ? wr_data : mem[a];
    end

    always_ff @(posedge clk) begin
      if (res) begin
        rd_data[gi*XLEN +: XLEN] <= '0;
        rd_valid[gi]             <= 1'b0;
      end else if (state == RUN && rd_en[gi]) begin
        rd_data[gi*XLEN +: XLEN] <= v;
        rd_valid[gi]             <= 1'b1;
      end else begin
        rd_valid[gi]             <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32x2 and a 24x3 instance share stimulus and are
// compared every cycle against a behavioural model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        res;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  re;
  logic [14:0] ra;

  logic        rdy_a, rdy_b;
  logic [63:0] rdd_a;
  logic [95:0] rdd_b;
  logic [1:0]  rdv_a;
  logic [2:0]  rdv_b;

  int checks = 0;
  int errors = 0;

  int dep [2] = '{32, 24};
  int nrp [2] = '{2, 3};

  logic [31:0] mm [2][32];
  int          since [2];
  logic        er [2];
  logic [31:0] ed [2][3];
  logic        ev [2][3];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2)) dut_a (
    .clk(clk), .res(res), .ready(rdy_a),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_en(re[1:0]), .rd_addr(ra[9:0]),
    .rd_data(rdd_a), .rd_valid(rdv_a)
  );

  regfile_mp #(.XLEN(32), .DEPTH(24), .NUM_RD(3)) dut_b (
    .clk(clk), .res(res), .ready(rdy_b),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_en(re), .rd_addr(ra),
    .rd_data(rdd_b), .rd_valid(rdv_b)
  );

  // Model: ready once DEPTH edges have passed since reset; memory reads
  // as all-zero from then on until software writes it.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (res) begin
        since[k] = 0;
        er[k]    = 1'b0;
        for (int p = 0; p < 3; p++) begin
          ed[k][p] = '0;
          ev[k][p] = 1'b0;
        end
      end else begin
        bit run = (since[k] >= dep[k]);
        for (int p = 0; p < nrp[k]; p++) begin
          int a = int'(ra[p*5 +: 5]);
          if (run && re[p]) begin
            if (a == 0 || a >= dep[k])
              ed[k][p] = '0;
            else if (we && int'(wa) == a)
              ed[k][p] = wd;
            else
              ed[k][p] = mm[k][a];
            ev[k][p] = 1'b1;
          end else begin
            ev[k][p] = 1'b0;
          end
        end
        if (run && we && wa != 0 && int'(wa) < dep[k])
          mm[k][wa] = wd;
        if (since[k] < 1000)
          since[k]++;
        if (since[k] == dep[k])
          for (int i = 0; i < 32; i++) mm[k][i] = '0;
        er[k] = (since[k] >= dep[k]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready_a", {31'b0, rdy_a}, {31'b0, er[0]});
    chk("ready_b", {31'b0, rdy_b}, {31'b0, er[1]});
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("data_a%0d", p), rdd_a[p*32 +: 32], ed[0][p]);
      chk($sformatf("valid_a%0d", p), {31'b0, rdv_a[p]}, {31'b0, ev[0][p]});
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("data_b%0d", p), rdd_b[p*32 +: 32], ed[1][p]);
      chk($sformatf("valid_b%0d", p), {31'b0, rdv_b[p]}, {31'b0, ev[1][p]});
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_wr(input logic e, input logic [4:0] a,
                        input logic [31:0] d);
    we = e;
    wa = a;
    wd = d;
  endtask

  task automatic set_rd(input logic [2:0] e, input logic [4:0] a0,
                        input logic [4:0] a1, input logic [4:0] a2);
    re = e;
    ra = {a2, a1, a0};
  endtask

  initial begin
    res = 1'b1;
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(3'b000, 5'd0, 5'd0, 5'd0);
    repeat (3) step();

    // Init: reads requested throughout must stay invalid until ready
    res = 1'b0;
    set_rd(3'b111, 5'd3, 5'd9, 5'd17);
    repeat (32) step();

    for (int a = 1; a < 32; a++) begin
      set_rd(3'b111, 5'(a), 5'(a), 5'(31 - a));
      step();
    end

    set_rd(3'b000, 5'd0, 5'd0, 5'd0);
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(3'b011, 5'd5, 5'd5, 5'd0);
    step();
    chk("r5_both_valid", {30'b0, rdv_a}, 32'd3);
    chk("r5_port1", rdd_a[63:32], 32'hDEADBEEF);

    set_wr(1'b1, 5'd7, 32'h12345678);
    set_rd(3'b001, 5'd7, 5'd0, 5'd0);
    step();
    chk("bypass_r7", rdd_a[31:0], 32'h12345678);

    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(3'b011, 5'd0, 5'd0, 5'd0);
    step();
    chk("x0_bypass", rdd_a[31:0], 32'h0);
    set_wr(1'b0, 5'd0, 32'd0);
    step();

    set_rd(3'b001, 5'd5, 5'd0, 5'd0);
    step();
    set_rd(3'b000, 5'd5, 5'd0, 5'd0);
    set_wr(1'b1, 5'd5, 32'h1);
    step();
    step();
    chk("hold_r5", rdd_a[31:0], 32'hDEADBEEF);
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(3'b001, 5'd5, 5'd0, 5'd0);
    step();
    chk("reenable_r5", rdd_a[31:0], 32'h1);

    for (int i = 0; i < 300; i++) begin
      set_wr(1'($urandom), 5'($urandom), $urandom);
      set_rd(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step();
    end

    // Out-of-range address on the 24-entry instance
    set_wr(1'b1, 5'd28, 32'hCAFEF00D);
    set_rd(3'b000, 5'd0, 5'd0, 5'd0);
    step();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(3'b111, 5'd28, 5'd28, 5'd28);
    step();
    chk("b_addr28", rdd_b[31:0], 32'h0);
    set_wr(1'b1, 5'd23, 32'h0BADC0DE);
    set_rd(3'b000, 5'd0, 5'd0, 5'd0);
    step();
    set_wr(1'b0, 5'd0, 32'd0);
    set_rd(3'b111, 5'd23, 5'd23, 5'd23);
    step();
    chk("b_r23_p2", rdd_b[95:64], 32'h0BADC0DE);

    set_wr(1'b1, 5'd9, 32'hA5A5A5A5);
    set_rd(3'b000, 5'd0, 5'd0, 5'd0);
    step();
    set_wr(1'b0, 5'd0, 32'd0);
    res = 1'b1;
    step();
    chk("ready_drop", {31'b0, rdy_a}, 32'd0);
    res = 1'b0;
    set_rd(3'b111, 5'd9, 5'd9, 5'd9);
    repeat (5) step();
    set_wr(1'b1, 5'd9, 32'h77777777);
    step();
    set_wr(1'b0, 5'd0, 32'd0);
    repeat (26) step();
    chk("r9_after_reinit", rdd_a[31:0], 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
